// File: rtl/sr_ff_bank.sv
// Bank of WIDTH bistable channels with run-time SR/JK/D/T update law and SR invalid tracking.
// q updates one edge after inputs are sampled; q_bar is ~q combinationally; no backpressure.
module sr_ff_bank #(
  parameter int                 WIDTH     = 8,
  parameter int                 SR_POLICY = 0,
  parameter int                 CNT_W     = 8,
  parameter logic [WIDTH-1:0]   RST_VAL   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clr_err,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  q_bar,
  output logic [WIDTH-1:0]  err_flags,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] upd;
  logic [WIDTH-1:0] inv;
  logic             any_inv;

  // Per-channel next value assuming an enabled, non-load edge.
  always_comb begin
    upd = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      unique case (mode)
        MODE_SR: begin
          unique case ({a[i], b[i]})
            2'b00: upd[i] = q_q[i];
            2'b10: upd[i] = 1'b1;
            2'b01: upd[i] = 1'b0;
            default: begin
              if (SR_POLICY == 1)      upd[i] = 1'b1;
              else if (SR_POLICY == 2) upd[i] = 1'b0;
              else                     upd[i] = q_q[i];
            end
          endcase
        end
        MODE_JK: begin
          unique case ({a[i], b[i]})
            2'b00: upd[i] = q_q[i];
            2'b10: upd[i] = 1'b1;
            2'b01: upd[i] = 1'b0;
            default: upd[i] = ~q_q[i];
          endcase
        end
        MODE_D:  upd[i] = a[i];
        MODE_T:  upd[i] = q_q[i] ^ a[i];
        default: upd[i] = q_q[i];
      endcase
    end
  end

  always_comb begin
    q_d = q_q;
    if (load)    q_d = load_val;
    else if (en) q_d = upd;
  end

  // Invalid only counts when the SR law actually applies on this edge.
  always_comb begin
    inv     = '0;
    if (en && !load && (mode == MODE_SR)) inv = a & b;
    any_inv = |inv;
  end

  always_comb begin
    flags_d = flags_q | inv;
    cnt_d   = cnt_q;
    if (any_inv && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    if (clr_err) begin
      flags_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= RST_VAL;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      q_q     <= q_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q         = q_q;
  assign q_bar     = ~q_q;
  assign err_flags = flags_q;
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed bench: three banks (hold / set-dominant / reset-dominant with 2-bit counter) share stimulus.
module tb_sr_ff_bank;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [7:0] a, b;
  logic       load;
  logic [7:0] load_val;
  logic       clr_err;

  logic [7:0] q0, qb0, f0, c0;
  logic [7:0] q1, qb1, f1, c1;
  logic [7:0] q2, qb2, f2;
  logic [1:0] c2;

  int total = 0;
  int bad   = 0;

  sr_ff_bank #(.WIDTH(8), .SR_POLICY(0), .CNT_W(8), .RST_VAL(8'hA5)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b),
    .load(load), .load_val(load_val), .clr_err(clr_err),
    .q(q0), .q_bar(qb0), .err_flags(f0), .err_cnt(c0));

  sr_ff_bank #(.WIDTH(8), .SR_POLICY(1), .CNT_W(8), .RST_VAL(8'h00)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b),
    .load(load), .load_val(load_val), .clr_err(clr_err),
    .q(q1), .q_bar(qb1), .err_flags(f1), .err_cnt(c1));

  sr_ff_bank #(.WIDTH(8), .SR_POLICY(2), .CNT_W(2), .RST_VAL(8'h00)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b),
    .load(load), .load_val(load_val), .clr_err(clr_err),
    .q(q2), .q_bar(qb2), .err_flags(f2), .err_cnt(c2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; mode = 2'b00; a = '0; b = '0;
    load = 1'b0; load_val = '0; clr_err = 1'b0;

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_q",      q0,  8'hA5);
    chk("rst_qbar",   qb0, 8'h5A);
    chk("rst_cnt",    c0,  8'h00);
    chk("rst_flags",  f0,  8'h00);
    chk("rst_q_dut2", q2,  8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Clear all channels
    load = 1'b1; load_val = 8'h00; en = 1'b1;
    tick();
    chk("load_zero", q0, 8'h00);
    load = 1'b0;

    // SR sweep on channel 0
    a = 8'h00; b = 8'h00; tick(); chk("sr00_p0", q0, 8'h00);
    a = 8'h01; b = 8'h00; tick(); chk("sr10_p0", q0, 8'h01);
    a = 8'h00; b = 8'h01; tick(); chk("sr01_p0", q0, 8'h00);
    a = 8'h01; b = 8'h01; tick();
    chk("sr11_p0_hold",  q0, 8'h00);
    chk("sr11_p1_set",   q1, 8'h01);
    chk("sr11_p2_rst",   q2, 8'h00);
    chk("sr11_flags",    f0, 8'h01);
    chk("sr11_cnt",      c0, 8'h01);
    chk("sr11_qbar_p1",  qb1, 8'hFE);

    // Channel 1 set, then invalid from q=1
    a = 8'h02; b = 8'h00; tick();
    chk("ch1_set_p0", q0, 8'h02);
    chk("ch1_set_p1", q1, 8'h03);
    a = 8'h02; b = 8'h02; tick();
    chk("ch1_inv_p0_hold", q0, 8'h02);
    chk("ch1_inv_p1_set",  q1, 8'h03);
    chk("ch1_inv_p2_rst",  q2, 8'h00);
    chk("ch1_inv_cnt",     c0, 8'h02);
    chk("ch1_inv_flags",   f0, 8'h03);

    // JK toggle then T
    load = 1'b1; load_val = 8'h00; tick(); load = 1'b0;
    mode = 2'b01; a = 8'hFF; b = 8'hFF;
    tick(); chk("jk_t1", q0, 8'hFF);
    tick(); chk("jk_t2", q0, 8'h00);
    tick(); chk("jk_t3", q0, 8'hFF);
    chk("jk_no_cnt", c0, 8'h02);
    mode = 2'b11; a = 8'h0F;
    tick(); chk("t_0f", q0, 8'hF0);

    // Load beats enabled SR invalid
    load = 1'b1; load_val = 8'h3C; en = 1'b1; mode = 2'b00; a = 8'hFF; b = 8'hFF;
    tick();
    chk("prio_q",     q0, 8'h3C);
    chk("prio_cnt",   c0, 8'h02);
    chk("prio_flags", f0, 8'h03);
    load = 1'b0; en = 1'b0;
    tick();
    chk("hold_q",   q0, 8'h3C);
    chk("hold_cnt", c0, 8'h02);

    // Clear errors without touching q
    clr_err = 1'b1;
    tick();
    chk("clr_cnt0",  c0, 8'h00);
    chk("clr_cnt2",  c2, 2'd0);
    chk("clr_keepq", q0, 8'h3C);
    clr_err = 1'b0;

    // Saturation on the 2-bit counter
    en = 1'b1;
    tick(); chk("sat1", c2, 2'd1);
    tick(); chk("sat2", c2, 2'd2);
    tick(); chk("sat3", c2, 2'd3);
    tick(); chk("sat4", c2, 2'd3);
    tick(); chk("sat5", c2, 2'd3);
    chk("cnt8_five", c0, 8'd5);

    clr_err = 1'b1;
    tick();
    chk("clr_wins_cnt",   c2, 2'd0);
    chk("clr_wins_flags", f2, 8'h00);
    chk("clr_wins_cnt0",  c0, 8'h00);
    clr_err = 1'b0;
    tick();
    chk("post_clr_cnt",   c2, 2'd1);
    chk("post_clr_flags", f0, 8'hFF);

    // Mode switch and mid-operation reset
    mode = 2'b10; a = 8'h81; b = 8'h00;
    tick(); chk("d_81", q0, 8'h81);
    mode = 2'b11; a = 8'h01;
    tick(); chk("t_80", q0, 8'h80);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_q",    q0,  8'hA5);
    chk("mid_rst_qbar", qb0, 8'h5A);
    chk("mid_rst_cnt",  c0,  8'h00);
    rst_n = 1'b1;
    tick();
    chk("post_rst_t0", q0, 8'hA4);
    chk("post_rst_t1", q1, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr_ff_bank.md
Name: sr_ff_bank

Overview:
- Parametrised bank of WIDTH clocked bistable channels.
- A run-time mode selects the per-cycle update law for every channel: SR, JK, D or T.
- Adds a compile-time SR invalid-input resolution policy, sticky per-channel invalid flags and a saturating invalid-event counter.
- Shared storage primitive for later counters and control blocks; replaces per-instance single-bit latches.

Parameters:
- WIDTH, 8: number of channels.
- SR_POLICY, 0: handling of s=r=1 in SR mode. 0 = hold, 1 = set-dominant, 2 = reset-dominant.
- CNT_W, 8: width of the invalid-event counter.
- RST_VAL, 0: WIDTH-bit reset value of q.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  update enable. When low, q holds.
- mode  input  2  00 = SR, 01 = JK, 10 = D, 11 = T.
- a  input  WIDTH  per-channel first operand: s / j / d / t.
- b  input  WIDTH  per-channel second operand: r / k. Ignored in D and T modes.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value loaded when load=1.
- clr_err  input  1  synchronous clear of err_flags and err_cnt.
- q  output  WIDTH  channel state.
- q_bar  output  WIDTH  always equals ~q, including during reset.
- err_flags  output  WIDTH  sticky per-channel SR invalid flags.
- err_cnt  output  CNT_W  saturating count of cycles with any SR invalid channel.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate, independent of clk):
  - q = RST_VAL, q_bar = ~RST_VAL.
  - err_flags = 0, err_cnt = 0.
  - Deassertion takes effect at the next rising edge. The first update happens on the first edge with rst_n=1.
- State update priority, evaluated each rising edge:
  1. load=1: q <= load_val, regardless of en and mode.
  2. en=1: per-channel update by mode.
  3. Otherwise q holds.
- Update laws, per channel i, next q (registered, 1-cycle latency, q valid after the edge):
  - SR: a=0,b=0 hold; a=1,b=0 set to 1; a=0,b=1 reset to 0; a=1,b=1 invalid, resolved by SR_POLICY (hold / 1 / 0).
  - JK: 00 hold, 10 set, 01 reset, 11 toggle.
  - D: q <= a.
  - T: a=1 toggles, a=0 holds.
- mode is sampled every edge. A mode change applies on the same edge it is sampled, with no pipeline and no state flush.
- Invalid detection:
  - Channel i is invalid on an edge when en=1, load=0, mode=SR and a[i]&b[i]=1.
  - err_flags[i] <= 1 on such an edge and then stays set.
  - err_cnt increments by exactly 1 per edge on which at least one channel is invalid, regardless of how many channels are invalid.
  - err_cnt saturates at 2^CNT_W-1 and never wraps.
- clr_err:
  - Synchronous. Clears err_flags and err_cnt on the edge where it is high.
  - If an invalid event occurs on that same edge, the clear wins: flags and count become 0. The event is not recorded.
  - clr_err does not affect q.
- load with SR invalid inputs present: no invalid is recorded, because load has priority.
- q_bar is combinationally ~q. No separate register, so no q/q_bar mismatch is possible.
- SR_POLICY values other than 0..2 behave as 0 (hold).
- All outputs are driven directly from registers or ~q. No combinational path exists from a, b or mode to q.

Test Plan:
- Reset: WIDTH=8, RST_VAL=8'hA5, assert rst_n=0 mid-cycle -> q=8'hA5 and q_bar=8'h5A immediately, before any edge; err_cnt=0, err_flags=0.
- SR sweep, channel 0, mode=00, en=1, {a,b} stepped 00,10,01,11 one edge each:
  - SR_POLICY=0 -> q[0] = hold, 1, 0, 0 (hold).
  - SR_POLICY=1 -> final step gives q[0]=1.
  - The 11 step sets err_flags[0]=1 and err_cnt=1.
- JK/T toggle: mode=01, a=b=8'hFF, from q=8'h00 over 3 edges -> 8'hFF, 8'h00, 8'hFF. Then mode=11, a=8'h0F, one edge -> q=8'hF0.
- Priority: load=1, load_val=8'h3C, en=1, mode=00, a=b=8'hFF on the same edge -> q=8'h3C, err_cnt unchanged. Next edge with en=0, load=0 -> q holds 8'h3C.
- Saturation and clear: CNT_W=2, 5 consecutive SR-invalid edges -> err_cnt = 1,2,3,3,3. clr_err=1 together with an invalid input -> err_cnt=0 and err_flags=0. The next invalid edge -> err_cnt=1.
- Mode switch and reset mid-operation: D mode, a=8'h81, one edge -> q=8'h81. Switch to T with a=8'h01 -> q=8'h80. Pulse rst_n low between edges -> q=RST_VAL at once; the next edge after release applies the current inputs.
